hazard_stall_ctrl: RTL and testbench

Parametrised successor to the pipeline load-use hazard unit in the 19-bit CPU. Sits between ID and EX.
- Detects load-use hazards with configurable register-address width, per-operand usage qualification and a configurable multi-cycle load stall length.
- Adds branch-taken flush of IF/ID and ID/EX, a global memory-wait freeze, and a saturating stall-cycle counter for performance tracking.

---
 rtl/cpu_pipe_pkg.sv | 33 +++
 rtl/sat_counter.sv | 28 ++
 rtl/hazard_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control definitions for the CPU hazard logic.
// Contents:
//   REG_AW_DEF  - default register address width
//   hz_state_e  - load-use stall FSM encoding (IDLE / STALL)
//   hz_ctrl_t   - hazard-control output bundle
//   HZ_CTRL_RST - bundle value for reset and for normal flow
package cpu_pipe_pkg;

  localparam int unsigned REG_AW_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic hazard;
    logic PCwrite;
    logic IF_IDwrite;
    logic IF_ID_flush;
    logic ID_EX_flush;
  } hz_ctrl_t;

  // Pipeline flows freely, nothing squashed.
  localparam hz_ctrl_t HZ_CTRL_RST = '{
    hazard:      1'b0,
    PCwrite:     1'b1,
    IF_IDwrite:  1'b1,
    IF_ID_flush: 1'b0,
    ID_EX_flush: 1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset, clears count
//   inc   - increment request for this cycle
//   count - current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard / stall controller sitting between ID and EX.
// Detects a load in EX whose destination is read by the instruction in ID and
// holds PC and IF/ID for LU_STALL cycles while bubbling ID/EX. Taken branches
// flush IF/ID and ID/EX and abort any stall; mem_wait freezes everything.
// Ports:
//   clk, rst_n             - clock and synchronous active-low reset
//   EX_memread, EX_rt      - load in EX and its destination register
//   ID_rs, ID_rt           - ID source registers
//   ID_rs_used, ID_rt_used - ID instruction actually reads that operand
//   branch_taken           - EX resolved a taken branch/jump
//   mem_wait               - data memory busy, freeze pipeline
//   hazard                 - bubble into ID/EX
//   PCwrite, IF_IDwrite    - PC and IF/ID write enables
//   IF_ID_flush, ID_EX_flush - squash IF/ID and ID/EX
//   stall_cnt              - saturating count of stalled cycles
module hazard_stall_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned LU_STALL  = 1,
  parameter bit          IGNORE_R0 = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EX_memread,
  input  logic [REG_AW-1:0] EX_rt,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_rs_used,
  input  logic              ID_rt_used,
  input  logic              branch_taken,
  input  logic              mem_wait,
  output logic              hazard,
  output logic              PCwrite,
  output logic              IF_IDwrite,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The first stall cycle is spent in IDLE, so STALL covers LU_STALL-1 cycles.
  localparam logic [3:0] REM_INIT = (LU_STALL > 1) ? 4'(LU_STALL - 2) : 4'd0;

  hz_state_e state_q, state_d;
  logic [3:0] rem_q, rem_d;
  hz_ctrl_t  ctrl;
  logic      stall_inc;
  logic      lu_hit;
  logic      r0_ok;

  assign r0_ok  = !IGNORE_R0 || (EX_rt != '0);
  assign lu_hit = EX_memread && r0_ok &&
                  ((ID_rs_used && (ID_rs == EX_rt)) || (ID_rt_used && (ID_rt == EX_rt)));

  // Outputs: mem_wait > branch_taken > STALL hold > lu_hit.
  always_comb begin
    ctrl      = HZ_CTRL_RST;
    stall_inc = 1'b0;
    if (!rst_n) begin
      ctrl = HZ_CTRL_RST;
    end else if (mem_wait) begin
      ctrl.PCwrite    = 1'b0;
      ctrl.IF_IDwrite = 1'b0;
      stall_inc       = 1'b1;
    end else if (branch_taken) begin
      ctrl.IF_ID_flush = 1'b1;
      ctrl.ID_EX_flush = 1'b1;
    end else if ((state_q == STALL) || lu_hit) begin
      ctrl.hazard     = 1'b1;
      ctrl.PCwrite    = 1'b0;
      ctrl.IF_IDwrite = 1'b0;
      stall_inc       = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (mem_wait) begin
      // EX is frozen and re-presents its branch/load, so hold everything.
      state_d = state_q;
    end else if (branch_taken) begin
      state_d = IDLE;
      rem_d   = 4'd0;
    end else if (state_q == STALL) begin
      if (rem_q == 4'd0) begin
        state_d = IDLE;
      end else begin
        rem_d = rem_q - 4'd1;
      end
    end else if (lu_hit && (LU_STALL > 1)) begin
      state_d = STALL;
      rem_d   = REM_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  assign hazard      = ctrl.hazard;
  assign PCwrite     = ctrl.PCwrite;
  assign IF_IDwrite  = ctrl.IF_IDwrite;
  assign IF_ID_flush = ctrl.IF_ID_flush;
  assign ID_EX_flush = ctrl.ID_EX_flush;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. Three instances share one input set:
//   dut0: LU_STALL=3, IGNORE_R0=0, CNT_W=16
//   dut1: LU_STALL=3, IGNORE_R0=1, CNT_W=2 (saturates at 3)
//   dut2: LU_STALL=1, IGNORE_R0=0, CNT_W=16
// Each step drives inputs on the falling edge, queues the expected outputs of
// all three instances, and compares them 2 ns later (before the rising edge).
module tb_hazard_stall_ctrl;

  localparam logic [4:0] RUN = 5'b01100;  // {hazard,PCwrite,IF_IDwrite,IF_ID_flush,ID_EX_flush}
  localparam logic [4:0] STL = 5'b10000;
  localparam logic [4:0] FLS = 5'b01111;
  localparam logic [4:0] FRZ = 5'b00000;

  logic       clk = 1'b0;
  logic       rst_n, EX_memread, ID_rs_used, ID_rt_used, branch_taken, mem_wait;
  logic [2:0] EX_rt, ID_rs, ID_rt;

  logic        hz0, pc0, ifw0, iff0, idf0;
  logic        hz1, pc1, ifw1, iff1, idf1;
  logic        hz2, pc2, ifw2, iff2, idf2;
  logic [15:0] cnt0, cnt2;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(3), .LU_STALL(3), .IGNORE_R0(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .EX_memread(EX_memread), .EX_rt(EX_rt), .ID_rs(ID_rs),
    .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .branch_taken(branch_taken), .mem_wait(mem_wait), .hazard(hz0), .PCwrite(pc0),
    .IF_IDwrite(ifw0), .IF_ID_flush(iff0), .ID_EX_flush(idf0), .stall_cnt(cnt0)
  );

  hazard_stall_ctrl #(.REG_AW(3), .LU_STALL(3), .IGNORE_R0(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .EX_memread(EX_memread), .EX_rt(EX_rt), .ID_rs(ID_rs),
    .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .branch_taken(branch_taken), .mem_wait(mem_wait), .hazard(hz1), .PCwrite(pc1),
    .IF_IDwrite(ifw1), .IF_ID_flush(iff1), .ID_EX_flush(idf1), .stall_cnt(cnt1)
  );

  hazard_stall_ctrl #(.REG_AW(3), .LU_STALL(1), .IGNORE_R0(1'b0), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .EX_memread(EX_memread), .EX_rt(EX_rt), .ID_rs(ID_rs),
    .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .branch_taken(branch_taken), .mem_wait(mem_wait), .hazard(hz2), .PCwrite(pc2),
    .IF_IDwrite(ifw2), .IF_ID_flush(iff2), .ID_EX_flush(idf2), .stall_cnt(cnt2)
  );

  typedef struct {
    string      name;
    logic       rstn, mr;
    logic [2:0] ex_rt, rs, rt;
    logic       rsu, rtu, br, mw;
    logic [4:0] e0, e1, e2;
    logic       chk;
    logic [15:0] c0, c1, c2;
  } step_t;

  typedef struct {
    string       name;
    int          dut;
    logic [4:0]  ctrl;
    logic        chk;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic step_t st(input string name, input logic rstn, input logic mr,
                               input logic [2:0] ex_rt, input logic [2:0] rs,
                               input logic [2:0] rt, input logic rsu, input logic rtu,
                               input logic br, input logic mw, input logic [4:0] e0,
                               input logic [4:0] e1, input logic [4:0] e2, input logic chk,
                               input int c0, input int c1, input int c2);
    step_t s;
    s.name = name; s.rstn = rstn; s.mr = mr; s.ex_rt = ex_rt; s.rs = rs; s.rt = rt;
    s.rsu = rsu; s.rtu = rtu; s.br = br; s.mw = mw;
    s.e0 = e0; s.e1 = e1; s.e2 = e2; s.chk = chk;
    s.c0 = 16'(c0); s.c1 = 16'(c1); s.c2 = 16'(c2);
    return s;
  endfunction

  task automatic drive(input step_t s);
    exp_t e;
    rst_n = s.rstn; EX_memread = s.mr; EX_rt = s.ex_rt; ID_rs = s.rs; ID_rt = s.rt;
    ID_rs_used = s.rsu; ID_rt_used = s.rtu; branch_taken = s.br; mem_wait = s.mw;
    e.name = s.name; e.chk = s.chk;
    e.dut = 0; e.ctrl = s.e0; e.cnt = s.c0; sb.push_back(e);
    e.dut = 1; e.ctrl = s.e1; e.cnt = s.c1; sb.push_back(e);
    e.dut = 2; e.ctrl = s.e2; e.cnt = s.c2; sb.push_back(e);
  endtask

  function automatic logic [20:0] get_obs(input int d);
    case (d)
      0:       return {hz0, pc0, ifw0, iff0, idf0, cnt0};
      1:       return {hz1, pc1, ifw1, iff1, idf1, 14'd0, cnt1};
      default: return {hz2, pc2, ifw2, iff2, idf2, cnt2};
    endcase
  endfunction

  task automatic test_reset();
    step_t q[$]; exp_t e; logic [20:0] o;
    q.push_back(st("rst_hold0",   0, 1, 2, 2, 0, 1, 0, 0, 0, RUN, RUN, RUN, 1, 0, 0, 0));
    q.push_back(st("rst_hold1",   0, 1, 2, 2, 0, 1, 0, 0, 0, RUN, RUN, RUN, 1, 0, 0, 0));
    q.push_back(st("rst_release", 1, 0, 2, 2, 0, 1, 0, 0, 0, RUN, RUN, RUN, 1, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = get_obs(e.dut); n_total++;
        if (o[20:16] !== e.ctrl || (e.chk && o[15:0] !== e.cnt))
          $display("FAIL %s dut%0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                   e.name, e.dut, o[20:16], o[15:0], e.ctrl, e.cnt);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_hazard();
    step_t q[$]; exp_t e; logic [20:0] o;
    q.push_back(st("nohz_diff",   1, 1, 1, 3, 2, 1, 1, 0, 0, RUN, RUN, RUN, 1, 0, 0, 0));
    q.push_back(st("nohz_unused", 1, 1, 4, 3, 4, 1, 0, 0, 0, RUN, RUN, RUN, 1, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = get_obs(e.dut); n_total++;
        if (o[20:16] !== e.ctrl || (e.chk && o[15:0] !== e.cnt))
          $display("FAIL %s dut%0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                   e.name, e.dut, o[20:16], o[15:0], e.ctrl, e.cnt);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // EX keeps presenting the matching load: 3-cycle instances ignore it while
  // in STALL, the 1-cycle instance re-detects it every cycle.
  task automatic test_load_use();
    step_t q[$]; exp_t e; logic [20:0] o;
    q.push_back(st("lu_c1",   1, 1, 4, 3, 4, 1, 1, 0, 0, STL, STL, STL, 1, 0, 0, 0));
    q.push_back(st("lu_c2",   1, 1, 4, 3, 4, 1, 1, 0, 0, STL, STL, STL, 1, 1, 1, 1));
    q.push_back(st("lu_c3",   1, 1, 4, 3, 4, 1, 1, 0, 0, STL, STL, STL, 1, 2, 2, 2));
    q.push_back(st("lu_done", 1, 0, 4, 3, 4, 1, 1, 0, 0, RUN, RUN, RUN, 1, 3, 3, 3));
    foreach (q[i]) begin
      drive(q[i]); #2;
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = get_obs(e.dut); n_total++;
        if (o[20:16] !== e.ctrl || (e.chk && o[15:0] !== e.cnt))
          $display("FAIL %s dut%0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                   e.name, e.dut, o[20:16], o[15:0], e.ctrl, e.cnt);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_r0();
    step_t q[$]; exp_t e; logic [20:0] o;
    q.push_back(st("r0_hit",  1, 1, 0, 0, 5, 1, 0, 0, 0, STL, RUN, STL, 1, 3, 3, 3));
    q.push_back(st("r0_s2",   1, 0, 0, 0, 5, 1, 0, 0, 0, STL, RUN, RUN, 1, 4, 3, 4));
    q.push_back(st("r0_s3",   1, 0, 0, 0, 5, 1, 0, 0, 0, STL, RUN, RUN, 1, 5, 3, 4));
    q.push_back(st("r0_done", 1, 0, 0, 0, 5, 1, 0, 0, 0, RUN, RUN, RUN, 1, 6, 3, 4));
    foreach (q[i]) begin
      drive(q[i]); #2;
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = get_obs(e.dut); n_total++;
        if (o[20:16] !== e.ctrl || (e.chk && o[15:0] !== e.cnt))
          $display("FAIL %s dut%0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                   e.name, e.dut, o[20:16], o[15:0], e.ctrl, e.cnt);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_abort();
    step_t q[$]; exp_t e; logic [20:0] o;
    q.push_back(st("br_s1",       1, 1, 4, 3, 4, 0, 1, 0, 0, STL, STL, STL, 1, 6, 3, 4));
    q.push_back(st("br_s2",       1, 0, 4, 3, 4, 0, 1, 1, 0, FLS, FLS, FLS, 1, 7, 3, 5));
    q.push_back(st("br_idle",     1, 0, 4, 3, 4, 0, 1, 0, 0, RUN, RUN, RUN, 1, 7, 3, 5));
    q.push_back(st("br_over_hit", 1, 1, 4, 3, 4, 0, 1, 1, 0, FLS, FLS, FLS, 1, 7, 3, 5));
    q.push_back(st("br_after",    1, 0, 4, 3, 4, 0, 1, 0, 0, RUN, RUN, RUN, 1, 7, 3, 5));
    foreach (q[i]) begin
      drive(q[i]); #2;
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = get_obs(e.dut); n_total++;
        if (o[20:16] !== e.ctrl || (e.chk && o[15:0] !== e.cnt))
          $display("FAIL %s dut%0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                   e.name, e.dut, o[20:16], o[15:0], e.ctrl, e.cnt);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // Two frozen cycles in the middle of a 3-cycle stall; the branch during the
  // freeze must be ignored and the stall must resume for its remaining cycles.
  task automatic test_mem_wait();
    step_t q[$]; exp_t e; logic [20:0] o;
    q.push_back(st("mw_s1",    1, 1, 4, 3, 4, 0, 1, 0, 0, STL, STL, STL, 1, 7, 3, 5));
    q.push_back(st("mw_w1",    1, 0, 4, 3, 4, 0, 1, 0, 1, FRZ, FRZ, FRZ, 1, 8, 3, 6));
    q.push_back(st("mw_w2_br", 1, 0, 4, 3, 4, 0, 1, 1, 1, FRZ, FRZ, FRZ, 1, 9, 3, 7));
    q.push_back(st("mw_s2",    1, 0, 4, 3, 4, 0, 1, 0, 0, STL, STL, RUN, 1, 10, 3, 8));
    q.push_back(st("mw_s3",    1, 0, 4, 3, 4, 0, 1, 0, 0, STL, STL, RUN, 1, 11, 3, 8));
    q.push_back(st("mw_done",  1, 0, 4, 3, 4, 0, 1, 0, 0, RUN, RUN, RUN, 1, 12, 3, 8));
    foreach (q[i]) begin
      drive(q[i]); #2;
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = get_obs(e.dut); n_total++;
        if (o[20:16] !== e.ctrl || (e.chk && o[15:0] !== e.cnt))
          $display("FAIL %s dut%0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                   e.name, e.dut, o[20:16], o[15:0], e.ctrl, e.cnt);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // Reset asserted mid-stall must clear the FSM and the counter.
  task automatic test_reset_mid();
    step_t q[$]; exp_t e; logic [20:0] o;
    q.push_back(st("rm_hit",    1, 1, 4, 3, 4, 0, 1, 0, 0, STL, STL, STL, 1, 12, 3, 8));
    q.push_back(st("rm_assert", 0, 1, 4, 3, 4, 0, 1, 0, 0, RUN, RUN, RUN, 0, 0, 0, 0));
    q.push_back(st("rm_after",  1, 0, 4, 3, 4, 0, 1, 0, 0, RUN, RUN, RUN, 1, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = get_obs(e.dut); n_total++;
        if (o[20:16] !== e.ctrl || (e.chk && o[15:0] !== e.cnt))
          $display("FAIL %s dut%0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                   e.name, e.dut, o[20:16], o[15:0], e.ctrl, e.cnt);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; EX_memread = 1'b0; EX_rt = '0; ID_rs = '0; ID_rt = '0;
    ID_rs_used = 1'b0; ID_rt_used = 1'b0; branch_taken = 1'b0; mem_wait = 1'b0;
    @(negedge clk);
    test_reset();
    test_no_hazard();
    test_load_use();
    test_r0();
    test_branch_abort();
    test_mem_wait();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
